// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for I-cache refill, D-cache refill/writeback and store-buffer drain; MEM_ARB_PERF_EN adds perf_* counters.
// One transaction at a time: grant edge -> mem_valid held until mem_ready -> one-cycle done; requests wait while BUSY/RESP.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int SB_MAX_WAIT = 8,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req,
    input  logic [ADDR_W-1:0]   ic_addr,
    output logic                ic_done,
    output logic [LINE_W-1:0]   ic_rdata,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [ADDR_W-1:0]   dc_addr,
    input  logic [LINE_W-1:0]   dc_wdata,
    output logic                dc_done,
    output logic [LINE_W-1:0]   dc_rdata,
    input  logic                sb_req,
    input  logic                sb_full,
    input  logic [ADDR_W-1:0]   sb_addr,
    input  logic [31:0]         sb_wdata,
    input  logic [3:0]          sb_be,
    output logic                sb_done,
`ifdef MEM_ARB_PERF_EN
    output logic [CNT_W-1:0]    perf_ic_grants,
    output logic [CNT_W-1:0]    perf_dc_grants,
    output logic [CNT_W-1:0]    perf_sb_grants,
    output logic [CNT_W-1:0]    perf_busy_cycles,
    output logic [CNT_W-1:0]    perf_sb_promotions,
`endif
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    output logic [LINE_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [LINE_W-1:0]   mem_rdata
);

    localparam int BE_W   = LINE_W / 8;
    localparam int WAIT_W = $clog2(SB_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SB_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC, OWN_SB} owner_t;

    state_t              state;
    owner_t              last_owner;
    logic [WAIT_W-1:0]   sb_wait_cnt;

    logic                sb_promote;
    logic                sb_hazard;
    owner_t              winner;
    logic                grant;
    logic                fmt_we;
    logic [ADDR_W-1:0]   fmt_addr;
    logic [LINE_W-1:0]   fmt_wdata;
    logic [BE_W-1:0]     fmt_be;

    // Word offsets below the line/word boundary never reach memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0], sb_addr[1:0]};

    // A D-cache read of a line with a pending store must see that store first.
    always_comb begin
        sb_promote = sb_req && (sb_full || (sb_wait_cnt >= WAIT_MAX));
        sb_hazard  = sb_req && dc_req && !dc_we &&
                     (sb_addr[ADDR_W-1:4] == dc_addr[ADDR_W-1:4]);
        winner = OWN_NONE;
        if (sb_promote || sb_hazard) winner = OWN_SB;
        else if (dc_req)             winner = OWN_DC;
        else if (ic_req)             winner = OWN_IC;
        else if (sb_req)             winner = OWN_SB;
    end

    assign grant = (state == IDLE) && (winner != OWN_NONE);

    always_comb begin
        fmt_we    = 1'b0;
        fmt_addr  = '0;
        fmt_wdata = '0;
        fmt_be    = '0;
        case (winner)
            OWN_IC: begin
                fmt_addr = {ic_addr[ADDR_W-1:4], 4'b0000};
            end
            OWN_DC: begin
                fmt_we    = dc_we;
                fmt_addr  = {dc_addr[ADDR_W-1:4], 4'b0000};
                fmt_wdata = dc_we ? dc_wdata : '0;
                fmt_be    = dc_we ? '1 : '0;
            end
            OWN_SB: begin
                fmt_we    = 1'b1;
                fmt_addr  = {sb_addr[ADDR_W-1:2], 2'b00};
                fmt_wdata = {(LINE_W/32){sb_wdata}};
                fmt_be    = BE_W'(sb_be) << {sb_addr[3:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= OWN_NONE;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
            sb_done    <= 1'b0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            sb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_owner <= winner;
                        mem_valid  <= 1'b1;
                        mem_we     <= fmt_we;
                        mem_addr   <= fmt_addr;
                        mem_wdata  <= fmt_wdata;
                        mem_be     <= fmt_be;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        case (last_owner)
                            OWN_IC: begin
                                ic_rdata <= mem_rdata;
                                ic_done  <= 1'b1;
                            end
                            OWN_DC: begin
                                dc_rdata <= mem_rdata;
                                dc_done  <= 1'b1;
                            end
                            OWN_SB: sb_done <= 1'b1;
                            default: ;
                        endcase
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Aging stalls only while the store buffer itself owns the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_wait_cnt <= '0;
        end else if (!sb_req || (grant && (winner == OWN_SB))) begin
            sb_wait_cnt <= '0;
        end else if (!((state != IDLE) && (last_owner == OWN_SB)) &&
                     (sb_wait_cnt < WAIT_MAX)) begin
            sb_wait_cnt <= sb_wait_cnt + WAIT_W'(1);
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ic_grants     <= '0;
            perf_dc_grants     <= '0;
            perf_sb_grants     <= '0;
            perf_busy_cycles   <= '0;
            perf_sb_promotions <= '0;
        end else begin
            if (grant && (winner == OWN_IC)) perf_ic_grants <= perf_ic_grants + CNT_W'(1);
            if (grant && (winner == OWN_DC)) perf_dc_grants <= perf_dc_grants + CNT_W'(1);
            if (grant && (winner == OWN_SB)) perf_sb_grants <= perf_sb_grants + CNT_W'(1);
            if (grant && sb_promote)         perf_sb_promotions <= perf_sb_promotions + CNT_W'(1);
            if (mem_valid)                   perf_busy_cycles <= perf_busy_cycles + CNT_W'(1);
        end
    end
`else
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be positive");
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a request-level priority/aging model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req, dc_req, dc_we, sb_req, sb_full, mem_ready;
    logic [ADDR_W-1:0] ic_addr, dc_addr, sb_addr;
    logic [LINE_W-1:0] dc_wdata, mem_rdata;
    logic [31:0]       sb_wdata;
    logic [3:0]        sb_be;
    logic              ic_done, dc_done, sb_done, mem_valid, mem_we;
    logic [LINE_W-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_be;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_ic_grants, perf_dc_grants, perf_sb_grants, perf_busy_cycles, perf_sb_promotions;
`endif

    int errors = 0;
    int checks = 0;
    int sb_age = 0;
    bit sb_owned = 0;
    int tb_busy = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .sb_req(sb_req), .sb_full(sb_full), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
        .sb_be(sb_be), .sb_done(sb_done),
`ifdef MEM_ARB_PERF_EN
        .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
        .perf_sb_grants(perf_sb_grants), .perf_busy_cycles(perf_busy_cycles),
        .perf_sb_promotions(perf_sb_promotions),
`endif
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Cycles the store buffer has been requesting without owning the port.
    always @(posedge clk) begin
        if (!reset || !sb_req || sb_owned) sb_age <= 0;
        else                               sb_age <= sb_age + 1;
    end

    always @(negedge clk) if (mem_valid === 1'b1) tb_busy <= tb_busy + 1;

    typedef struct {
        bit                ok;
        bit                stable;
        int                waitc;
        int                exp_own;
        logic [2:0]        dv;
        logic [2:0]        dv_after;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [15:0]       be;
        logic [LINE_W-1:0] wd;
        logic [LINE_W-1:0] rd_seen;
    } obs_t;

    // Owner codes: 1 = I-cache, 2 = D-cache, 3 = store buffer. sb_age includes the grant edge itself.
    function automatic int predict();
        if (sb_req && (sb_full || sb_age >= 9)) return 3;
        if (sb_req && dc_req && !dc_we && (sb_addr / 16) == (dc_addr / 16)) return 3;
        if (dc_req) return 2;
        if (ic_req) return 1;
        if (sb_req) return 3;
        return 0;
    endfunction

    function automatic logic [2:0] onehot(input int own);
        logic [2:0] v = 3'b000;
        if (own >= 1 && own <= 3) v[own-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int own);
        if (own == 1) return ic_addr - (ic_addr % 16);
        if (own == 2) return dc_addr - (dc_addr % 16);
        return sb_addr - (sb_addr % 4);
    endfunction

    function automatic logic exp_we(input int own);
        return (own == 3) || (own == 2 && dc_we);
    endfunction

    function automatic logic [15:0] exp_be(input int own);
        logic [15:0] b = {12'b0, sb_be};
        if (own == 3) return b << (4 * ((sb_addr / 4) % 4));
        if (own == 2 && dc_we) return 16'hFFFF;
        return 16'h0000;
    endfunction

    function automatic logic [LINE_W-1:0] exp_wd(input int own);
        if (own == 3) return {sb_wdata, sb_wdata, sb_wdata, sb_wdata};
        return dc_wdata;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory model: waits for mem_valid, holds ready low for lat cycles, returns rd.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd, output obs_t o);
        int n = 0;
        o.ok = 0; o.stable = 1; o.exp_own = 0; o.dv = 0; o.dv_after = 0;
        o.addr = 0; o.we = 0; o.be = 0; o.wd = 0; o.rd_seen = 0;
        while (mem_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        o.waitc = n;
        if (mem_valid !== 1'b1) return;
        o.ok = 1;
        o.exp_own = predict();
        if (o.exp_own == 3) sb_owned = 1;
        o.addr = mem_addr; o.we = mem_we; o.be = mem_be; o.wd = mem_wdata;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || mem_addr !== o.addr || mem_we !== o.we ||
                mem_be !== o.be || mem_wdata !== o.wd) o.stable = 0;
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = ~rd;
        o.dv = {sb_done, dc_done, ic_done};
        if (o.exp_own == 1)      o.rd_seen = ic_rdata;
        else if (o.exp_own == 2) o.rd_seen = dc_rdata;
        @(negedge clk);
        o.dv_after = {sb_done, dc_done, ic_done};
        sb_owned = 0;
    endtask

    task automatic drop(input int own);
        if (own == 1) ic_req = 1'b0;
        if (own == 2) dc_req = 1'b0;
        if (own == 3) sb_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        checks++; if ({ic_done, dc_done, sb_done} !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", {ic_done, dc_done, sb_done}); end
        checks++; if (mem_addr !== '0 || mem_we !== 1'b0 || mem_be !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_fields: addr %h we %b be %h", mem_addr, mem_we, mem_be); end
        checks++; if (ic_rdata !== '0 || dc_rdata !== '0) begin errors++; $display("FAIL reset_rdata: ic %h dc %h want 0", ic_rdata, dc_rdata); end
    endtask

    task automatic test_ic_refill();
        obs_t o;
        logic [LINE_W-1:0] rd = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
        ic_req = 1'b1; ic_addr = 32'h1004;
        serve(3, rd, o);
        drop(1);
        checks++; if (o.ok !== 1'b1) begin errors++; $display("FAIL ic_timeout: no mem_valid after %0d cycles", o.waitc); end
        checks++; if (o.addr !== 32'h1000 || o.we !== 1'b0) begin errors++; $display("FAIL ic_mem_req: addr %h we %b want 1000 0", o.addr, o.we); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL ic_stable: mem outputs changed while waiting for ready"); end
        checks++; if (o.dv !== 3'b001 || o.dv_after !== 3'b000) begin errors++; $display("FAIL ic_done_pulse: got %b then %b want 001 then 000", o.dv, o.dv_after); end
        checks++; if (o.rd_seen !== rd) begin errors++; $display("FAIL ic_rdata: got %h want %h", o.rd_seen, rd); end
    endtask

    task automatic test_three_way();
        obs_t o;
        int order [3] = '{2, 1, 3};
        int pulses = 0;
        ic_req = 1'b1; ic_addr = 32'h4040;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h2000;
        sb_req = 1'b1; sb_full = 1'b0; sb_addr = 32'h3000; sb_be = 4'hF; sb_wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            serve(0, rand_line(), o);
            pulses += $countones(o.dv) + $countones(o.dv_after);
            checks++; if (o.dv !== onehot(order[i])) begin errors++; $display("FAIL three_way_order[%0d]: done %b want %b", i, o.dv, onehot(order[i])); end
            checks++; if (o.addr !== exp_addr(order[i])) begin errors++; $display("FAIL three_way_addr[%0d]: got %h want %h", i, o.addr, exp_addr(order[i])); end
            drop(order[i]);
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL three_way_pulses: got %0d want 3", pulses); end
    endtask

    task automatic test_hazard();
        obs_t o;
        sb_req = 1'b1; sb_full = 1'b0; sb_addr = 32'h104; sb_be = 4'b0010; sb_wdata = 32'h0000_7700;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h100;
        serve(1, rand_line(), o);
        checks++; if (o.dv !== 3'b100) begin errors++; $display("FAIL hazard_sb_first: done %b want 100", o.dv); end
        checks++; if (o.be !== 16'h0020 || o.addr !== 32'h104 || o.we !== 1'b1) begin errors++; $display("FAIL hazard_sb_fmt: be %h addr %h we %b want 0020 104 1", o.be, o.addr, o.we); end
        checks++; if (o.wd !== {4{32'h0000_7700}}) begin errors++; $display("FAIL hazard_sb_wdata: got %h", o.wd); end
        drop(3);
        serve(0, rand_line(), o);
        checks++; if (o.dv !== 3'b010 || o.addr !== 32'h100) begin errors++; $display("FAIL hazard_dc_next: done %b addr %h want 010 100", o.dv, o.addr); end
        drop(2);
    endtask

    task automatic test_aging();
        obs_t o;
        bit sb_seen = 0;
        ic_req = 1'b1; ic_addr = 32'h7000;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h6000;
        sb_req = 1'b1; sb_full = 1'b0; sb_addr = 32'h5004; sb_be = 4'h3; sb_wdata = $urandom;
        for (int i = 0; i < 12 && !sb_seen; i++) begin
            serve($urandom_range(0, 3), rand_line(), o);
            checks++; if (o.dv !== onehot(o.exp_own)) begin errors++; $display("FAIL aging_grant[%0d]: done %b want %b (sb_age %0d)", i, o.dv, onehot(o.exp_own), sb_age); end
            if (o.exp_own == 3 || o.dv[2] === 1'b1) begin
                sb_seen = 1;
                drop(3);
            end
            dc_addr = 32'h6000 + 32'($urandom_range(0, 15)) * 16;
        end
        checks++; if (!sb_seen) begin errors++; $display("FAIL aging_sb_served: got 0 want 1"); end
        sb_req = 1'b1; sb_full = 1'b1; sb_addr = 32'h5008;
        serve(0, rand_line(), o);
        checks++; if (o.dv !== 3'b100) begin errors++; $display("FAIL sb_full_priority: done %b want 100", o.dv); end
        drop(3); sb_full = 1'b0;
        serve(0, rand_line(), o);
        drop(2);
        serve(0, rand_line(), o);
        checks++; if (o.dv !== 3'b001) begin errors++; $display("FAIL aging_drain_ic: done %b want 001", o.dv); end
        drop(1);
    endtask

    task automatic test_random();
        obs_t o;
        logic [LINE_W-1:0] rd;
        for (int i = 0; i < 40; i++) begin
            if (!ic_req && $urandom_range(0, 1) == 1) begin ic_req = 1'b1; ic_addr = $urandom; end
            if (!dc_req && $urandom_range(0, 1) == 1) begin
                dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1));
                dc_addr = 32'h100 + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 15));
                dc_wdata = rand_line();
            end
            if (!sb_req && $urandom_range(0, 1) == 1) begin
                sb_req = 1'b1; sb_be = 4'($urandom_range(1, 15)); sb_wdata = $urandom;
                sb_addr = 32'h100 + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 15));
            end
            sb_full = ($urandom_range(0, 3) == 0);
            if (!ic_req && !dc_req && !sb_req) begin ic_req = 1'b1; ic_addr = $urandom; end
            rd = rand_line();
            serve($urandom_range(0, 3), rd, o);
            checks++; if (o.ok !== 1'b1 || o.dv !== onehot(o.exp_own) || o.dv_after !== 3'b000) begin
                errors++; $display("FAIL rand_grant[%0d]: ok %b done %b/%b want %b", i, o.ok, o.dv, o.dv_after, onehot(o.exp_own)); end
            checks++; if (o.addr !== exp_addr(o.exp_own) || o.we !== exp_we(o.exp_own) || o.be !== exp_be(o.exp_own)) begin
                errors++; $display("FAIL rand_fmt[%0d]: addr %h we %b be %h want %h %b %h", i, o.addr, o.we, o.be, exp_addr(o.exp_own), exp_we(o.exp_own), exp_be(o.exp_own)); end
            if (o.we === 1'b1) begin
                checks++; if (o.wd !== exp_wd(o.exp_own)) begin errors++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, o.wd, exp_wd(o.exp_own)); end
            end
            if (o.exp_own == 1 || o.exp_own == 2) begin
                checks++; if (o.rd_seen !== rd || o.stable !== 1'b1) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h stable %b", i, o.rd_seen, rd, o.stable); end
            end
            drop(o.exp_own);
        end
        ic_req = 1'b0; dc_req = 1'b0; sb_req = 1'b0; sb_full = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int n = 0;
        logic [LINE_W-1:0] rd = rand_line();
        ic_req = 1'b1; ic_addr = 32'h8008;
        while (mem_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: mem_valid %b want 1", mem_valid); end
        reset = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || {ic_done, dc_done, sb_done} !== 3'b000) begin errors++; $display("FAIL mid_reset_clear: valid %b done %b want 0 000", mem_valid, {ic_done, dc_done, sb_done}); end
        repeat (2) @(negedge clk);
        checks++; if ({ic_done, dc_done, sb_done} !== 3'b000) begin errors++; $display("FAIL mid_reset_no_done: got %b want 000", {ic_done, dc_done, sb_done}); end
        reset = 1'b1;
        serve(1, rd, o);
        drop(1);
        checks++; if (o.waitc != 1 || o.dv !== 3'b001 || o.addr !== 32'h8000) begin errors++; $display("FAIL mid_reset_resume: wait %0d done %b addr %h want 1 001 8000", o.waitc, o.dv, o.addr); end
        checks++; if (o.rd_seen !== rd) begin errors++; $display("FAIL mid_reset_rdata: got %h want %h", o.rd_seen, rd); end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        int base;
        reset = 1'b0;
        @(negedge clk);
        base = tb_busy;
        reset = 1'b1;
        test_three_way();
        @(negedge clk);
        checks++; if (perf_ic_grants !== 32'd1 || perf_dc_grants !== 32'd1 || perf_sb_grants !== 32'd1) begin
            errors++; $display("FAIL perf_grants: ic %0d dc %0d sb %0d want 1 1 1", perf_ic_grants, perf_dc_grants, perf_sb_grants); end
        checks++; if (perf_busy_cycles !== 32'(tb_busy - base)) begin errors++; $display("FAIL perf_busy: got %0d want %0d", perf_busy_cycles, tb_busy - base); end
        checks++; if (perf_sb_promotions !== 32'd0) begin errors++; $display("FAIL perf_promotions: got %0d want 0", perf_sb_promotions); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        ic_req = 0; dc_req = 0; dc_we = 0; sb_req = 0; sb_full = 0; mem_ready = 0;
        ic_addr = '0; dc_addr = '0; sb_addr = '0; dc_wdata = '0; mem_rdata = '0;
        sb_wdata = '0; sb_be = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_ic_refill();
        test_three_way();
        test_hazard();
        test_aging();
        test_random();
        test_reset_mid();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port arbiter/sequencer for shared main memory.
- Shares the port among I-cache line refill, D-cache line refill/writeback, and store-buffer word drain.
- Sits between the fetch stage, the mem stage (cache plus store buffer) and the data memory model.
- Serves one transaction at a time over a valid/ready handshake.
- Enforces SB-before-D-cache-read ordering on same-line conflicts and bounds SB starvation with an aging counter.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits (4 words).
- SB_MAX_WAIT, 8, cycles an SB request may wait before it is promoted to top priority.
- CNT_W, 32, width of performance counters (used only when the optional feature is enabled).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req  in  1  I-cache line read request; held until ic_done.
- ic_addr  in  ADDR_W  I-cache miss address.
- ic_done  out  1  one-cycle pulse; ic_rdata valid.
- ic_rdata  out  LINE_W  refilled line.
- dc_req  in  1  D-cache request; held until dc_done.
- dc_we  in  1  1 = line writeback, 0 = line refill.
- dc_addr  in  ADDR_W  D-cache address.
- dc_wdata  in  LINE_W  writeback line.
- dc_done  out  1  one-cycle completion pulse.
- dc_rdata  out  LINE_W  refilled line.
- sb_req  in  1  SB drain request; held until sb_done.
- sb_full  in  1  store buffer full.
- sb_addr  in  ADDR_W  store word address.
- sb_wdata  in  32  store data.
- sb_be  in  4  byte enables.
- sb_done  out  1  one-cycle completion pulse.
- mem_valid  out  1  transaction presented to memory.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  write data.
- mem_be  out  LINE_W/8  byte enables.
- mem_ready  in  1  memory completes the presented transaction this cycle.
- mem_rdata  in  LINE_W  read line, valid with mem_ready.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; sb_wait_cnt = 0; last_owner = NONE.
- Reset asserted mid-transaction abandons it: no done pulse is issued, and memory is reset by the same signal.

FSM:
- IDLE: when any request is present, register the winner and its request fields, set mem_valid = 1 on the next edge, and go to BUSY. With no requests, stay in IDLE.
- BUSY: mem_valid and all mem_* outputs are held stable. When mem_ready = 1, capture mem_rdata into the winner's rdata, drop mem_valid, and go to RESP.
- RESP: pulse the winner's done for exactly one cycle, then go to IDLE.
- Best case: request sampled at edge k, mem_valid high after k, mem_ready in that cycle, done high in cycle k+1..k+2, next grant decided at edge k+3.

Priority (evaluated in IDLE only, highest first):
1. SB, when sb_req and (sb_full or sb_wait_cnt >= SB_MAX_WAIT).
2. SB, when sb_req, dc_req, !dc_we and sb_addr[ADDR_W-1:4] == dc_addr[ADDR_W-1:4] (ordering hazard).
3. D-cache.
4. I-cache.
5. SB.

sb_wait_cnt:
- Increments each cycle sb_req = 1 and SB is not the current owner.
- Saturates at SB_MAX_WAIT.
- Clears when SB is granted or sb_req = 0.

Memory formatting:
- Line transactions: mem_addr = {addr[ADDR_W-1:4], 4'b0}; mem_be = all ones for writes, 0 for reads.
- SB transactions: mem_we = 1; mem_addr = {sb_addr[ADDR_W-1:2], 2'b0}; mem_wdata = sb_wdata replicated 4 times; mem_be = sb_be shifted to byte lane 4*sb_addr[3:2], other lanes 0.

Rules and boundary cases:
- rdata outputs hold their last value until the next capture.
- A requester dropping req while in BUSY is a protocol violation; the transaction still completes and done still pulses.
- Simultaneous requests are resolved only by the priority rules above.
- A request arriving during BUSY/RESP waits for IDLE.
- Never more than one done output high in any cycle.

Optional Feature:
- Macro MEM_ARB_PERF_EN enables read-only counters: ic_grants, dc_grants, sb_grants, busy_cycles (cycles mem_valid = 1), sb_promotions (grants via rule 1). Each is CNT_W wide, wrapping, cleared by reset, and exposed as outputs perf_*.
- Without the macro, the counters and their ports do not exist and behaviour is otherwise identical.

Test Plan:
- Lone ic_req, addr 0x1004; memory ready after 3 cycles with rdata 0x...DEADBEEF -> mem_addr = 0x1000, mem_we = 0; ic_done pulses once; ic_rdata matches.
- ic_req, dc_req (read 0x2000) and sb_req (0x3000) asserted together, no aging -> grant order D-cache, I-cache, SB; exactly three done pulses.
- sb_req for addr 0x104 with sb_be = 4'b0010, data 0x00007700, plus dc_req read at 0x100 -> SB granted first; mem_be = 0x0020; then D-cache read.
- Continuous dc_req and ic_req with sb_req pending -> SB granted no later than the grant decision after sb_wait_cnt reaches 8; sb_full = 1 gives immediate SB priority.
- Reset asserted low while in BUSY -> mem_valid and all done outputs 0 immediately; FSM back in IDLE; a new ic_req after release is served normally.
- With MEM_ARB_PERF_EN, run the scenario-2 sequence -> each grant counter = 1; busy_cycles equals the total number of mem_valid cycles.
